decode_stage: RTL

//  DE stage of the 5-stage in-order RV32I pipeline: consumes FE latch, decodes op/imm, reads regfile,

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decode_stage_if.sv | 44 ++++
 rtl/decode_stage_regfile.sv | 53 +++++
 rtl/decode_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcode values,
// instruction field widths, the decoded-op enum and immediate formats.
package decode_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [F7_W-1:0] F7_ZERO = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0,
        OP_LUI     = 6'd1,
        OP_AUIPC   = 6'd2,
        OP_JAL     = 6'd3,
        OP_JALR    = 6'd4,
        OP_BEQ     = 6'd5,
        OP_BNE     = 6'd6,
        OP_BLT     = 6'd7,
        OP_BGE     = 6'd8,
        OP_BLTU    = 6'd9,
        OP_BGEU    = 6'd10,
        OP_LW      = 6'd11,
        OP_SW      = 6'd12,
        OP_ADDI    = 6'd13,
        OP_SLTI    = 6'd14,
        OP_SLTIU   = 6'd15,
        OP_XORI    = 6'd16,
        OP_ORI     = 6'd17,
        OP_ANDI    = 6'd18,
        OP_SLLI    = 6'd19,
        OP_SRLI    = 6'd20,
        OP_SRAI    = 6'd21,
        OP_ADD     = 6'd22,
        OP_SUB     = 6'd23,
        OP_SLL     = 6'd24,
        OP_SLT     = 6'd25,
        OP_SLTU    = 6'd26,
        OP_XOR     = 6'd27,
        OP_SRL     = 6'd28,
        OP_SRA     = 6'd29,
        OP_OR      = 6'd30,
        OP_AND     = 6'd31
    } op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/decode_stage_if.sv
// FE latch, flush, writeback and DE latch signals of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    import decode_pkg::*;

    logic                fe_valid_i;
    logic [INST_W-1:0]   fe_inst_i;
    logic [XLEN-1:0]     fe_pc_i;
    logic [XLEN-1:0]     fe_pcplus_i;
    logic [31:0]         fe_icount_i;
    logic                flush_i;
    logic                wb_we_i;
    logic [REG_W-1:0]    wb_rd_i;
    logic [XLEN-1:0]     wb_data_i;

    logic                stall_fe_o;
    logic                de_valid_o;
    logic [5:0]          de_op_o;
    logic                de_we_o;
    logic [REG_W-1:0]    de_rd_o;
    logic [XLEN-1:0]     de_rs1_val_o;
    logic [XLEN-1:0]     de_rs2_val_o;
    logic [XLEN-1:0]     de_imm_o;
    logic [XLEN-1:0]     de_pc_o;
    logic [XLEN-1:0]     de_pcplus_o;
    logic [31:0]         de_icount_o;

    modport master (
        output fe_valid_i, fe_inst_i, fe_pc_i, fe_pcplus_i, fe_icount_i,
        output flush_i, wb_we_i, wb_rd_i, wb_data_i,
        input  stall_fe_o, de_valid_o, de_op_o, de_we_o, de_rd_o,
        input  de_rs1_val_o, de_rs2_val_o, de_imm_o, de_pc_o, de_pcplus_o, de_icount_o
    );

    modport slave (
        input  fe_valid_i, fe_inst_i, fe_pc_i, fe_pcplus_i, fe_icount_i,
        input  flush_i, wb_we_i, wb_rd_i, wb_data_i,
        output stall_fe_o, de_valid_o, de_op_o, de_we_o, de_rd_o,
        output de_rs1_val_o, de_rs2_val_o, de_imm_o, de_pc_o, de_pcplus_o, de_icount_o
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two async read ports, one sync write port,
// x0 hardwired to zero, same-cycle write bypassed onto the read ports.
module regfile_2r1w #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next register contents: apply the writeback, never to x0.
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Register storage, cleared by async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with x0 forced to zero and writeback bypass.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the FE latch, reads operands, tracks in-flight
// writers per register, stalls FE on RAW hazards and drives the DE latch.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned SBCNTBITS = 2
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);

    logic [INST_W-1:0] inst;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [REG_W-1:0]  rd, rs1, rs2;

    assign inst   = bus.fe_inst_i;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    op_e             dec_op;
    imm_fmt_e        dec_fmt;
    logic            dec_writes, dec_use1, dec_use2, dec_we;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // Opcode/funct decode into op, immediate format, rd write and rs use flags.
    always_comb begin
        dec_op     = OP_ILLEGAL;
        dec_fmt    = IMM_NONE;
        dec_writes = 1'b0;
        dec_use1   = 1'b0;
        dec_use2   = 1'b0;
        unique case (opcode)
            OPC_LUI:   begin dec_op = OP_LUI;   dec_fmt = IMM_U; dec_writes = 1'b1; end
            OPC_AUIPC: begin dec_op = OP_AUIPC; dec_fmt = IMM_U; dec_writes = 1'b1; end
            OPC_JAL:   begin dec_op = OP_JAL;   dec_fmt = IMM_J; dec_writes = 1'b1; end
            OPC_JALR: begin
                dec_fmt = IMM_I; dec_writes = 1'b1; dec_use1 = 1'b1;
                if (funct3 == 3'd0) dec_op = OP_JALR;
            end
            OPC_BRANCH: begin
                dec_fmt = IMM_B; dec_use1 = 1'b1; dec_use2 = 1'b1;
                case (funct3)
                    3'd0:    dec_op = OP_BEQ;
                    3'd1:    dec_op = OP_BNE;
                    3'd4:    dec_op = OP_BLT;
                    3'd5:    dec_op = OP_BGE;
                    3'd6:    dec_op = OP_BLTU;
                    3'd7:    dec_op = OP_BGEU;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                dec_fmt = IMM_I; dec_writes = 1'b1; dec_use1 = 1'b1;
                if (funct3 == 3'd2) dec_op = OP_LW;
            end
            OPC_STORE: begin
                dec_fmt = IMM_S; dec_use1 = 1'b1; dec_use2 = 1'b1;
                if (funct3 == 3'd2) dec_op = OP_SW;
            end
            OPC_OPIMM: begin
                dec_fmt = IMM_I; dec_writes = 1'b1; dec_use1 = 1'b1;
                case (funct3)
                    3'd0: dec_op = OP_ADDI;
                    3'd2: dec_op = OP_SLTI;
                    3'd3: dec_op = OP_SLTIU;
                    3'd4: dec_op = OP_XORI;
                    3'd6: dec_op = OP_ORI;
                    3'd7: dec_op = OP_ANDI;
                    3'd1: if (funct7 == F7_ZERO) dec_op = OP_SLLI;
                    default: begin
                        if (funct7 == F7_ZERO)     dec_op = OP_SRLI;
                        else if (funct7 == F7_ALT) dec_op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                dec_writes = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1;
                case ({funct7, funct3})
                    {F7_ZERO, 3'd0}: dec_op = OP_ADD;
                    {F7_ALT,  3'd0}: dec_op = OP_SUB;
                    {F7_ZERO, 3'd1}: dec_op = OP_SLL;
                    {F7_ZERO, 3'd2}: dec_op = OP_SLT;
                    {F7_ZERO, 3'd3}: dec_op = OP_SLTU;
                    {F7_ZERO, 3'd4}: dec_op = OP_XOR;
                    {F7_ZERO, 3'd5}: dec_op = OP_SRL;
                    {F7_ALT,  3'd5}: dec_op = OP_SRA;
                    {F7_ZERO, 3'd6}: dec_op = OP_OR;
                    {F7_ZERO, 3'd7}: dec_op = OP_AND;
                    default:         dec_op = OP_ILLEGAL;
                endcase
            end
            default: dec_op = OP_ILLEGAL;
        endcase
        // Illegal encodings neither write nor read registers.
        if (dec_op == OP_ILLEGAL) begin
            dec_fmt    = IMM_NONE;
            dec_writes = 1'b0;
            dec_use1   = 1'b0;
            dec_use2   = 1'b0;
        end
        dec_we = dec_writes && (rd != '0);
    end

    // Sign-extended immediate selected by format.
    always_comb begin
        dec_imm = '0;
        case (dec_fmt)
            IMM_I:   dec_imm = XLEN'($signed(inst[31:20]));
            IMM_S:   dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:   dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:   dec_imm = XLEN'($signed({inst[31:12], 12'h000}));
            IMM_J:   dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: dec_imm = '0;
        endcase
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (REG_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val),
        .we_i     (bus.wb_we_i),
        .waddr_i  (bus.wb_rd_i),
        .wdata_i  (bus.wb_data_i)
    );

    logic [SBCNTBITS-1:0] sb_cnt_q [NREGS];
    logic [SBCNTBITS-1:0] sb_cnt_d [NREGS];
    logic                 haz_rs1, haz_rs2, hazard, latch_insn, sb_inc, sb_dec;

    // RAW hazard: a source still has a pending writer after this cycle's retire.
    always_comb begin
        haz_rs1 = dec_use1 && (sb_cnt_q[rs1] != '0) &&
                  !(bus.wb_we_i && (bus.wb_rd_i == rs1) && (sb_cnt_q[rs1] == SBCNTBITS'(1)));
        haz_rs2 = dec_use2 && (sb_cnt_q[rs2] != '0) &&
                  !(bus.wb_we_i && (bus.wb_rd_i == rs2) && (sb_cnt_q[rs2] == SBCNTBITS'(1)));
        hazard     = bus.fe_valid_i && (haz_rs1 || haz_rs2);
        latch_insn = bus.fe_valid_i && !hazard && !bus.flush_i;
        sb_inc     = latch_insn && dec_we;
        sb_dec     = bus.wb_we_i && (bus.wb_rd_i != '0);
    end

    assign bus.stall_fe_o = hazard && !bus.flush_i;

    // Scoreboard update: +1 on issue, -1 on retire, saturating at both ends.
    always_comb begin
        sb_cnt_d = sb_cnt_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (sb_inc && (rd == REG_W'(r)) && !(sb_dec && (bus.wb_rd_i == REG_W'(r)))) begin
                if (sb_cnt_q[r] != '1) sb_cnt_d[r] = sb_cnt_q[r] + SBCNTBITS'(1);
            end else if (sb_dec && (bus.wb_rd_i == REG_W'(r)) && !(sb_inc && (rd == REG_W'(r)))) begin
                if (sb_cnt_q[r] != '0) sb_cnt_d[r] = sb_cnt_q[r] - SBCNTBITS'(1);
            end
        end
    end

    // Scoreboard counters, cleared by async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                sb_cnt_q[r] <= '0;
            end
        end else begin
            sb_cnt_q <= sb_cnt_d;
        end
    end

    sb_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(sb_dec && !(sb_inc && (rd == bus.wb_rd_i)) && (sb_cnt_q[bus.wb_rd_i] == '0)));

    logic              de_valid_q, de_valid_d;
    op_e               de_op_q, de_op_d;
    logic              de_we_q, de_we_d;
    logic [REG_W-1:0]  de_rd_q, de_rd_d;
    logic [XLEN-1:0]   de_rs1_q, de_rs1_d, de_rs2_q, de_rs2_d, de_imm_q, de_imm_d;
    logic [XLEN-1:0]   de_pc_q, de_pc_d, de_pcplus_q, de_pcplus_d;
    logic [31:0]       de_icount_q, de_icount_d;

    // DE latch next value: the decoded insn, or an all-zero bubble.
    always_comb begin
        de_valid_d  = 1'b0;
        de_op_d     = OP_ILLEGAL;
        de_we_d     = 1'b0;
        de_rd_d     = '0;
        de_rs1_d    = '0;
        de_rs2_d    = '0;
        de_imm_d    = '0;
        de_pc_d     = '0;
        de_pcplus_d = '0;
        de_icount_d = '0;
        if (latch_insn) begin
            de_valid_d  = 1'b1;
            de_op_d     = dec_op;
            de_we_d     = dec_we;
            de_rd_d     = rd;
            de_rs1_d    = rs1_val;
            de_rs2_d    = rs2_val;
            de_imm_d    = dec_imm;
            de_pc_d     = bus.fe_pc_i;
            de_pcplus_d = bus.fe_pcplus_i;
            de_icount_d = bus.fe_icount_i;
        end
    end

    // DE latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_valid_q  <= 1'b0;
            de_op_q     <= OP_ILLEGAL;
            de_we_q     <= 1'b0;
            de_rd_q     <= '0;
            de_rs1_q    <= '0;
            de_rs2_q    <= '0;
            de_imm_q    <= '0;
            de_pc_q     <= '0;
            de_pcplus_q <= '0;
            de_icount_q <= '0;
        end else begin
            de_valid_q  <= de_valid_d;
            de_op_q     <= de_op_d;
            de_we_q     <= de_we_d;
            de_rd_q     <= de_rd_d;
            de_rs1_q    <= de_rs1_d;
            de_rs2_q    <= de_rs2_d;
            de_imm_q    <= de_imm_d;
            de_pc_q     <= de_pc_d;
            de_pcplus_q <= de_pcplus_d;
            de_icount_q <= de_icount_d;
        end
    end

    assign bus.de_valid_o   = de_valid_q;
    assign bus.de_op_o      = de_op_q;
    assign bus.de_we_o      = de_we_q;
    assign bus.de_rd_o      = de_rd_q;
    assign bus.de_rs1_val_o = de_rs1_q;
    assign bus.de_rs2_val_o = de_rs2_q;
    assign bus.de_imm_o     = de_imm_q;
    assign bus.de_pc_o      = de_pc_q;
    assign bus.de_pcplus_o  = de_pcplus_q;
    assign bus.de_icount_o  = de_icount_q;

endmodule
